// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RISC-V opcode constants and the
// funct3/funct7 operation map common to register and immediate forms.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_XOR     = 4'b0001,
        ALU_SUB     = 4'b0010,
        ALU_OR      = 4'b0011,
        ALU_ADD     = 4'b0100,
        ALU_SRA     = 4'b0101,
        ALU_EQ      = 4'b1000,
        ALU_SLL     = 4'b1001,
        ALU_LUI     = 4'b1010,
        ALU_SRL     = 4'b1100,
        ALU_SLT     = 4'b1110,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    // Where the ALU B operand comes from.
    typedef enum logic [1:0] {
        SRCB_RS2   = 2'd0,
        SRCB_IMM   = 2'd1,
        SRCB_SHAMT = 2'd2
    } srcb_sel_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 map shared by R-type and I-type; only the register form
    // may select SUB, the immediate form always adds.
    function automatic alu_op_e funct3_op(input logic [2:0] funct3,
                                          input logic [6:0] funct7,
                                          input logic       is_reg);
        alu_op_e op;
        op = ALU_ILLEGAL;
        case (funct3)
            3'b000: begin
                if (!is_reg)                op = ALU_ADD;
                else if (funct7 == F7_BASE) op = ALU_ADD;
                else if (funct7 == F7_ALT)  op = ALU_SUB;
            end
            3'b111: op = ALU_AND;
            3'b110: op = ALU_OR;
            3'b100: op = ALU_XOR;
            3'b010: op = ALU_SLT;
            3'b001: op = ALU_SLL;
            3'b101: begin
                if (funct7 == F7_BASE)     op = ALU_SRL;
                else if (funct7 == F7_ALT) op = ALU_SRA;
            end
            default: op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational map from instruction fields to ALU operation,
// B-operand source and illegal flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] operation,
    output logic [1:0] srcb_sel,
    output logic       illegal
);

    alu_op_e   op;
    srcb_sel_e sel;

    // Decode the opcode class, then refine by funct3/funct7.
    always_comb begin
        // NOTE: defaults first so every path assigns op/sel and no latch is inferred.
        op  = ALU_ILLEGAL;
        sel = SRCB_RS2;
        case (opcode)
            OPC_RTYPE: op = funct3_op(funct3, funct7, 1'b1);
            OPC_ITYPE: begin
                op  = funct3_op(funct3, funct7, 1'b0);
                sel = (funct3 == 3'b001 || funct3 == 3'b101) ? SRCB_SHAMT : SRCB_IMM;
            end
            OPC_LUI: begin
                op  = ALU_LUI;
                sel = SRCB_IMM;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                op  = ALU_ADD;
                sel = SRCB_IMM;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: op = ALU_EQ;
                    3'b100:         op = ALU_SLT;
                    default:        op = ALU_ILLEGAL;
                endcase
            end
            default: op = ALU_ILLEGAL;
        endcase
    end

    assign operation = op;
    assign srcb_sel  = sel;
    assign illegal   = (op == ALU_ILLEGAL);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction into an ALU request and holds it
// in a single-entry output register with valid/ready handshakes both sides.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_illegal,
    output logic [CNT_WIDTH-1:0]     issue_count
);

    logic [3:0]            dec_op;
    logic [1:0]            dec_sel;
    logic                  dec_illegal;
    logic [DATA_WIDTH-1:0] srcb_next;
    logic                  load;
    logic                  xfer;

    alu_op_decode u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .operation (dec_op),
        .srcb_sel  (dec_sel),
        .illegal   (dec_illegal)
    );

    // Select the B operand: register, immediate or zero-extended shift amount.
    always_comb begin
        srcb_next = rs2_data;
        case (srcb_sel_e'(dec_sel))
            SRCB_IMM:   srcb_next = imm;
            SRCB_SHAMT: srcb_next = {{(DATA_WIDTH-5){1'b0}}, imm[4:0]};
            default:    srcb_next = rs2_data;
        endcase
    end

    // The slot can accept whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign xfer     = out_valid && out_ready && !flush;

    // Output register: flush wins, then a new load, then a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset too so a discarded request never leaks stale operands.
            out_valid   <= 1'b0;
            SrcA        <= '0;
            SrcB        <= '0;
            Operation   <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            out_valid   <= 1'b1;
            SrcA        <= rs1_data;
            SrcB        <= srcb_next;
            Operation   <= OPCODE_LENGTH'(dec_op);
            out_illegal <= dec_illegal;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed downstream transfers, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
        end else if (xfer) begin
            issue_count <= issue_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, ALU Operation code width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, issued-operation counter width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-007 SHALL have inputs opcode 7, funct3 3, funct7 7: the instruction fields.
REQ-008 SHALL have inputs rs1_data, rs2_data and imm, each DATA_WIDTH: the register operands and the sign-extended immediate.
REQ-009 SHALL have input flush 1, which discards the held operation.
REQ-010 SHALL have outputs out_valid 1 and input out_ready 1, the downstream (ALU stage) handshake.
REQ-011 SHALL have outputs SrcA and SrcB (DATA_WIDTH), Operation (OPCODE_LENGTH) and out_illegal 1: the registered ALU request.
REQ-012 SHALL have output issue_count  CNT_WIDTH  count of accepted downstream transfers.

Function
REQ-013 SHALL decode combinationally and capture into a single-entry output register; latency from input accept to out_valid is exactly 1 cycle.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, so full throughput is back-to-back with no bubble.
REQ-015 SHALL load the register when in_valid && in_ready and flush is low; out_valid then goes 1.
REQ-016 SHALL clear out_valid when out_valid && out_ready and no new load occurs in that cycle.
REQ-017 SHALL hold SrcA, SrcB, Operation and out_illegal stable while out_valid && !out_ready.
REQ-018 SHALL, on flush, clear out_valid on the next edge and ignore any simultaneous input; flush takes priority over both load and transfer.
REQ-019 SHALL increment issue_count by 1 on each out_valid && out_ready cycle with flush low, wrapping from all-ones to 0.
REQ-020 SHALL always set SrcA = rs1_data.
REQ-021 SHALL handle R-type (0110011) with SrcB = rs2; funct3/funct7 map: 000/0000000 ADD 0100; 000/0100000 SUB 0010; 111 AND 0000; 110 OR 0011; 100 XOR 0001; 010 SLT 1110; 001 SLL 1001; 101/0000000 SRL 1100; 101/0100000 SRA 0101.
REQ-022 SHALL handle I-type ALU (0010011) with SrcB = imm and the same funct3 map (ADDI never SUB); for shifts, SrcB = imm[4:0] zero-extended and funct7 selects SRLI/SRAI.
REQ-023 SHALL map LUI (0110111) to 1010 with SrcB = imm.
REQ-024 SHALL map load (0000011), store (0100011) and JALR (1100111) to ADD 0100 with SrcB = imm.
REQ-025 SHALL map branch (1100011) with SrcB = rs2: funct3 000/001 -> Equal 1000; 100 -> SLT 1110.
REQ-026 SHALL, for any other opcode/funct combination, set Operation = 1111 and out_illegal = 1; illegal operations are still issued and counted.

Reset
REQ-027 SHALL, while rst_n = 0, force out_valid 0, SrcA 0, SrcB 0, Operation 0000, out_illegal 0 and issue_count 0 asynchronously.
REQ-028 SHALL make in_ready read 1 during reset, with no load taken until rst_n is released.
REQ-029 SHALL discard a held operation if reset is asserted mid-transfer; the count is not incremented.

Structure
REQ-030 SHALL take the Operation codes (AND, XOR, SUB, OR, ADD, EQ, SLL, SRL, SRA, LUI, SLT, ILLEGAL) and the RISC-V opcode constants from the shared package alu_pkg, which the ALU also uses.
REQ-031 SHALL contain one sub-module, alu_op_decode: a purely combinational map from fields to {Operation, SrcB select, illegal}.

Verification
REQ-032 SHALL cover: R-type funct3 000, funct7 0100000, rs1 10, rs2 3 -> next cycle out_valid 1, Operation 0010, SrcA 10, SrcB 3.
REQ-033 SHALL cover: SRAI with imm 0x00000405 -> Operation 0101, SrcB 5.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles -> outputs stable, in_ready 0; release -> transfer, issue_count +1.
REQ-035 SHALL cover: flush asserted in the same cycle as in_valid -> out_valid 0 next cycle, issue_count unchanged.
REQ-036 SHALL cover: opcode 1111111 -> Operation 1111, out_illegal 1; separately, preset issue_count to 0xFFFF, then one transfer -> 0x0000.
REQ-037 SHALL cover: rst_n pulsed low mid-stall -> out_valid 0 immediately, without waiting for clk.
